// File: rtl/srv_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory-controller port of srv_mem_arbiter.
// The slave modport is the arbiter's own view; master is the requester/memory side.
interface srv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);
  logic              m0_req_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic              m0_rsp_o;
  logic [LINE_W-1:0] m0_data_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic              m1_rsp_o;
  logic [LINE_W-1:0] m1_data_o;
  logic              m1_err_o;

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rsp_i;
  logic [LINE_W-1:0] mem_data_i;

  logic              busy_o;
  logic              grant_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m1_req_i, m1_addr_i, mem_rsp_i, mem_data_i,
    output m0_rsp_o, m0_data_o, m0_err_o, m1_rsp_o, m1_data_o, m1_err_o,
    output mem_req_o, mem_addr_o, busy_o, grant_o
  );

  modport master (
    output m0_req_i, m0_addr_i, m1_req_i, m1_addr_i, mem_rsp_i, mem_data_i,
    input  m0_rsp_o, m0_data_o, m0_err_o, m1_rsp_o, m1_data_o, m1_err_o,
    input  mem_req_o, mem_addr_o, busy_o, grant_o
  );
endinterface

// File: rtl/srv_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory controller,
// with a per-transaction wait timeout that returns an error response.
module srv_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst_n,
  srv_mem_arbiter_if.slave bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [LINE_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              win_s;

  // Next-state, arbitration and response generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    rsp0_d       = 1'b0;
    rsp1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    data0_d      = data0_q;
    data1_d      = data1_q;
    win_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          // On a tie the requester that did not win last time goes first
          if (bus.m0_req_i && bus.m1_req_i) begin
            win_s = ~last_grant_q;
          end else begin
            win_s = bus.m1_req_i;
          end
          mem_addr_d   = win_s ? bus.m1_addr_i : bus.m0_addr_i;
          grant_d      = win_s;
          last_grant_d = win_s;
          mem_req_d    = 1'b1;
          cnt_d        = 16'd0;
          state_d      = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // A real response beats a timeout landing in the same cycle
        if (bus.mem_rsp_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (grant_q) begin
            data1_d = bus.mem_data_i;
            rsp1_d  = 1'b1;
          end else begin
            data0_d = bus.mem_data_i;
            rsp0_d  = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (grant_q) begin
            data1_d = {LINE_W{1'b0}};
            rsp1_d  = 1'b1;
            err1_d  = 1'b1;
          end else begin
            data0_d = {LINE_W{1'b0}};
            rsp0_d  = 1'b1;
            err0_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; last_grant resets to 1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      data0_q      <= {LINE_W{1'b0}};
      data1_q      <= {LINE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
    end
  end

  assign bus.m0_rsp_o   = rsp0_q;
  assign bus.m0_data_o  = data0_q;
  assign bus.m0_err_o   = err0_q;
  assign bus.m1_rsp_o   = rsp1_q;
  assign bus.m1_data_o  = data1_q;
  assign bus.m1_err_o   = err1_q;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.busy_o     = busy_q;
  assign bus.grant_o    = grant_q;

endmodule

// File: tb/tb_srv_mem_arbiter.sv
// Directed bench for srv_mem_arbiter: stimulus pushes expected responses into a
// queue, and a negedge monitor pops and compares each response pulse.
module tb_srv_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;
  localparam int unsigned TO = 8;

  typedef struct {
    logic          who;
    logic [LW-1:0] data;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t mon_e;

  srv_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  srv_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input logic who, input logic [AW-1:0] addr);
    chk1("grant_mem_req", bus.mem_req_o, 1'b1);
    chka("grant_addr", bus.mem_addr_o, addr);
    chk1("grant_idx", bus.grant_o, who);
    chk1("grant_busy", bus.busy_o, 1'b1);
  endtask

  // Called in a BUSY cycle; with give_rsp the response arrives lat-1 cycles later,
  // otherwise the bench waits out the remaining TO cycles for the timeout.
  task automatic serve(input logic who, input int lat, input logic [LW-1:0] d, input bit give_rsp);
    exp_t e;
    e.who  = who;
    e.err  = !give_rsp;
    e.data = give_rsp ? d : {LW{1'b0}};
    exp_q.push_back(e);
    if (give_rsp) begin
      for (int c = 1; c < lat; c++) begin
        chk1("busy_mem_req", bus.mem_req_o, 1'b1);
        tick();
      end
      bus.mem_rsp_i  = 1'b1;
      bus.mem_data_i = d;
      tick();
      bus.mem_rsp_i  = 1'b0;
      bus.mem_data_i = {LW{1'b0}};
    end else begin
      for (int c = 1; c <= lat; c++) begin
        chk1("wait_mem_req", bus.mem_req_o, 1'b1);
        tick();
      end
    end
    chk1("resp_mem_req_clr", bus.mem_req_o, 1'b0);
    chk1("resp_busy", bus.busy_o, 1'b1);
    if (who) chk1("resp_m1_pulse", bus.m1_rsp_o, 1'b1);
    else     chk1("resp_m0_pulse", bus.m0_rsp_o, 1'b1);
  endtask

  task automatic finish_resp();
    tick();
    chk1("idle_m0_rsp", bus.m0_rsp_o, 1'b0);
    chk1("idle_m1_rsp", bus.m1_rsp_o, 1'b0);
    chk1("idle_m0_err", bus.m0_err_o, 1'b0);
    chk1("idle_m1_err", bus.m1_err_o, 1'b0);
    chk1("idle_busy", bus.busy_o, 1'b0);
    chk1("idle_mem_req", bus.mem_req_o, 1'b0);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (bus.m0_rsp_o || bus.m1_rsp_o)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got m0_rsp=%0b m1_rsp=%0b want no response", bus.m0_rsp_o, bus.m1_rsp_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk1("sb_m0_rsp", bus.m0_rsp_o, (mon_e.who == 1'b0));
        chk1("sb_m1_rsp", bus.m1_rsp_o, (mon_e.who == 1'b1));
        if (mon_e.who) begin
          chkd("sb_m1_data", bus.m1_data_o, mon_e.data);
          chk1("sb_m1_err", bus.m1_err_o, mon_e.err);
        end else begin
          chkd("sb_m0_data", bus.m0_data_o, mon_e.data);
          chk1("sb_m0_err", bus.m0_err_o, mon_e.err);
        end
      end
    end
  end

  initial begin
    logic [LW-1:0] d;
    logic [AW-1:0] a;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.m0_req_i  = 1'b0;
    bus.m0_addr_i = {AW{1'b0}};
    bus.m1_req_i  = 1'b0;
    bus.m1_addr_i = {AW{1'b0}};
    bus.mem_rsp_i = 1'b0;
    bus.mem_data_i = {LW{1'b0}};

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk1("rst_grant", bus.grant_o, 1'b0);
    chk1("rst_m0_rsp", bus.m0_rsp_o, 1'b0);
    chk1("rst_m1_rsp", bus.m1_rsp_o, 1'b0);
    chka("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chkd("rst_m0_data", bus.m0_data_o, 128'h0);
    rst_n = 1'b1;
    tick();

    // Tie held across four arbitrations: m0, m1, m0, m1
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0100;
    bus.m1_req_i  = 1'b1;
    bus.m1_addr_i = 32'h0000_0200;
    for (int r = 0; r < 4; r++) begin
      tick();
      a = r[0] ? 32'h0000_0200 : 32'h0000_0100;
      check_grant(r[0], a);
      d = {32'hCAFE_0000 | 32'(r), 96'h1234_5678_9ABC_DEF0_1357_2468};
      serve(r[0], r + 1, d, 1'b1);
      if (r == 3) begin
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
      end
      finish_resp();
    end

    // Single request, response three cycles after the grant
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0040;
    tick();
    check_grant(1'b0, 32'h0000_0040);
    serve(1'b0, 3, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5, 1'b1);
    bus.m0_req_i = 1'b0;
    finish_resp();
    chkd("m0_data_hold", bus.m0_data_o, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5);

    // m1 arrives while m0 is busy and is served right after
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0300;
    tick();
    check_grant(1'b0, 32'h0000_0300);
    bus.m1_req_i  = 1'b1;
    bus.m1_addr_i = 32'h0000_0400;
    tick();
    chk1("hold_grant_kept", bus.grant_o, 1'b0);
    chka("hold_addr_kept", bus.mem_addr_o, 32'h0000_0300);
    serve(1'b0, 2, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);
    bus.m0_req_i = 1'b0;
    finish_resp();
    chk1("hold_idle_grant", bus.grant_o, 1'b0);
    tick();
    check_grant(1'b1, 32'h0000_0400);
    serve(1'b1, 2, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001, 1'b1);
    bus.m1_req_i = 1'b0;
    finish_resp();

    // Timeout on m1, then a late response that must be ignored
    bus.m1_req_i  = 1'b1;
    bus.m1_addr_i = 32'h0000_0500;
    tick();
    check_grant(1'b1, 32'h0000_0500);
    serve(1'b1, TO, 128'h0, 1'b0);
    bus.m1_req_i   = 1'b0;
    bus.mem_rsp_i  = 1'b1;
    bus.mem_data_i = {LW{1'b1}};
    tick();
    chk1("late_busy", bus.busy_o, 1'b0);
    tick();
    bus.mem_rsp_i  = 1'b0;
    bus.mem_data_i = {LW{1'b0}};
    chk1("late_m1_rsp", bus.m1_rsp_o, 1'b0);
    chk1("late_mem_req", bus.mem_req_o, 1'b0);
    chkd("late_m1_data", bus.m1_data_o, 128'h0);

    // Response on exactly the timeout cycle wins
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0900;
    tick();
    check_grant(1'b0, 32'h0000_0900);
    serve(1'b0, TO, 128'hDEAD_BEEF_0000_0000_0000_0000_C0DE_0008, 1'b1);
    bus.m0_req_i = 1'b0;
    finish_resp();

    // Asynchronous reset in the middle of a transaction
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0600;
    tick();
    check_grant(1'b0, 32'h0000_0600);
    tick();
    bus.mem_rsp_i  = 1'b1;
    bus.mem_data_i = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_mem_req", bus.mem_req_o, 1'b0);
    chk1("arst_busy", bus.busy_o, 1'b0);
    chk1("arst_grant", bus.grant_o, 1'b0);
    chka("arst_mem_addr", bus.mem_addr_o, 32'h0);
    chk1("arst_m0_rsp", bus.m0_rsp_o, 1'b0);
    chkd("arst_m0_data", bus.m0_data_o, 128'h0);
    chkd("arst_m1_data", bus.m1_data_o, 128'h0);
    bus.m0_req_i   = 1'b0;
    bus.mem_rsp_i  = 1'b0;
    bus.mem_data_i = {LW{1'b0}};
    tick();
    rst_n = 1'b1;
    tick();
    chk1("arst_no_fwd", bus.m0_rsp_o, 1'b0);

    // First tie after reset goes to m0
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0700;
    bus.m1_req_i  = 1'b1;
    bus.m1_addr_i = 32'h0000_0800;
    tick();
    check_grant(1'b0, 32'h0000_0700);
    serve(1'b0, 2, 128'h0707_0707_0707_0707_0707_0707_0707_0707, 1'b1);
    bus.m0_req_i = 1'b0;
    finish_resp();
    tick();
    check_grant(1'b1, 32'h0000_0800);
    serve(1'b1, 1, 128'h0808_0808_0808_0808_0808_0808_0808_0808, 1'b1);
    bus.m1_req_i = 1'b0;
    finish_resp();

    repeat (2) tick();
    chka("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srv_mem_arbiter.md
SRV_MEM_ARBITER -- requirements
Module: srv_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the request address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, meaning the returned line width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, legal range 1..65535, meaning the maximum cycles waited for mem_rsp_i.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port m0_req_i, input, 1 bit: requester 0 (instruction cache refill) request; held high until m0_rsp_o.
REQ-007 The block SHALL have port m0_addr_i, input, ADDR_W bits: requester 0 line address; stable while m0_req_i is high.
REQ-008 The block SHALL have ports m0_rsp_o (output, 1 bit), m0_data_o (output, LINE_W bits) and m0_err_o (output, 1 bit): requester 0 response pulse, line data and timeout flag.
REQ-009 The block SHALL have ports m1_req_i, m1_addr_i, m1_rsp_o, m1_data_o and m1_err_o, identical in direction, width and meaning to the m0 set, serving requester 1 (data/debug loader).
REQ-010 The block SHALL have port mem_req_o, output, 1 bit: request to the shared memory controller.
REQ-011 The block SHALL have port mem_addr_o, output, ADDR_W bits: registered address of the granted request.
REQ-012 The block SHALL have port mem_rsp_i, input, 1 bit: single-cycle completion pulse from the memory controller.
REQ-013 The block SHALL have port mem_data_i, input, LINE_W bits: line data, valid in the cycle mem_rsp_i is high.
REQ-014 The block SHALL have ports busy_o (output, 1 bit: state is not IDLE) and grant_o (output, 1 bit: index of the current or last granted requester).

Function
REQ-015 The block SHALL implement a state machine with states IDLE, BUSY and RESP.
REQ-016 IDLE -> BUSY: at a clock edge where any mX_req_i is high; the winner's address is latched into mem_addr_o, grant_o is updated, and mem_req_o is set.
REQ-017 Arbitration SHALL be round-robin: if both requests are high, the requester not equal to last_grant wins; if one is high, it wins; last_grant updates on every grant.
REQ-018 In BUSY, mem_req_o SHALL stay high and mem_addr_o stable until mem_rsp_i is high or the timeout fires.
REQ-019 BUSY -> RESP on mem_rsp_i=1: mem_data_i is latched into the granted mX_data_o, mem_req_o clears, and in RESP the granted mX_rsp_o=1 with mX_err_o=0 for exactly one cycle.
REQ-020 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_rsp_i.
REQ-021 When the counter equals TIMEOUT-1 and mem_rsp_i=0, the next state SHALL be RESP with mX_err_o=1, mX_data_o=0 and mem_req_o cleared.
REQ-022 If mem_rsp_i and the timeout condition coincide, the response SHALL take priority (err=0, data latched).
REQ-023 RESP -> IDLE unconditionally after one cycle; rsp_o and err_o return to 0; data_o holds until the next response to that requester.
REQ-024 mem_rsp_i in IDLE or RESP (for example, a late response after a timeout) SHALL be ignored with no state or output change.
REQ-025 Minimum latency: request seen at edge 0, mem_req_o high from edge 0; mem_rsp_i in cycle k gives mX_rsp_o in cycle k+1; the next arbitration is at the edge after RESP.
REQ-026 A requester SHALL drop its request in the cycle following its rsp_o; a request still high in IDLE is treated as a new request.
REQ-027 Request inputs SHALL be ignored outside IDLE; the non-granted request waits without loss.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, counter=0, last_grant=1 (so m0 wins the first tie), grant_o=0, and all other outputs 0, including mid-transaction; an in-flight mem_rsp_i is not forwarded.

Verification
REQ-029 Single request: m0 requests address 0x0000_0040; mem_rsp_i arrives 3 cycles later with data 0x...A5 -> mem_addr_o=0x40; m0_rsp_o is high for 1 cycle carrying the data, with m0_err_o=0.
REQ-030 Tie: m0 and m1 request in the same cycle, repeated 4 times -> grant order is m0, m1, m0, m1.
REQ-031 Timeout: TIMEOUT=8 with no mem_rsp_i -> m1_rsp_o=1 and m1_err_o=1 in the 9th cycle after the grant, m1_data_o=0; a late mem_rsp_i is then ignored.
REQ-032 Coincidence: mem_rsp_i arrives exactly on the timeout cycle -> err=0 and data is delivered.
REQ-033 Reset mid-BUSY: rst_n is pulsed while mem_req_o=1 -> all outputs are 0 immediately, and the next tie grants m0.
REQ-034 Hold: m1 requests while m0 is BUSY -> m1 is granted at the edge after m0's RESP, and mem_addr_o equals m1_addr_i.
